op_dispatch_scheduler: RTL

OP_DISPATCH_SCHEDULER -- requirements
Module: op_dispatch_scheduler

---
 rtl/op_dispatch_if.sv | 25 ++
 rtl/op_dispatch_scheduler.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/op_dispatch_if.sv
// Request/dispatch bundle for op_dispatch_scheduler.
// master = requester/sink side, slave = scheduler side.
interface op_dispatch_if;
  logic [3:0]  req_valid;
  logic [63:0] req_op;
  logic [3:0]  req_ready;
  logic [15:0] idx_op;
  logic        op_strobe;

  modport master (
    output req_valid,
    output req_op,
    input  req_ready,
    input  idx_op,
    input  op_strobe
  );

  modport slave (
    input  req_valid,
    input  req_op,
    output req_ready,
    output idx_op,
    output op_strobe
  );
endinterface

// File: rtl/op_dispatch_scheduler.sv
// Round-robin op arbiter, pending-op FIFO and IDLE/DRIVE/GAP dispatcher.
// Optional DISPATCH_DROP_COUNT_EN adds an 8-bit saturating drop counter.
module op_dispatch_scheduler #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  op_dispatch_if.slave bus,
  output logic         busy,
  output logic [2:0]   fifo_count,
  output logic         illegal_pulse
`ifdef DISPATCH_DROP_COUNT_EN
  ,
  output logic [7:0]   drop_cnt
`endif
);

  localparam int unsigned AW =
    (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP
  } state_e;

  state_e      state_q;
  logic [3:0]  hold_q;
  logic [15:0] idx_q;
  logic        strobe_q;
  logic        illegal_q;

  logic [1:0]  rr_q;
  logic [1:0]  rr_d;

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] wp_d;
  logic [AW-1:0] rp_q;
  logic [AW-1:0] rp_d;
  logic [2:0]    cnt_q;
  logic [2:0]    cnt_d;

  logic        full;
  logic        empty;
  logic [1:0]  cand;
  logic [1:0]  gidx;
  logic        gval;
  logic [3:0]  grant;
  logic [15:0] op_w;
  logic        drop;
  logic        push;
  logic        pop;

  assign full  = (cnt_q == 3'(FIFO_DEPTH));
  assign empty = (cnt_q == 3'd0);

  // Scan from the slot after the last grant; full FIFO or reset blocks all.
  always_comb begin
    cand = rr_q;
    gidx = rr_q;
    gval = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = rr_q + 2'(k);
      if (!gval && bus.req_valid[cand]) begin
        gval = 1'b1;
        gidx = cand;
      end
    end
    if (full || !rst_n) begin
      gval = 1'b0;
    end
    grant = gval ? (4'b0001 << gidx) : 4'b0000;
  end

  assign bus.req_ready = grant;

  assign op_w = bus.req_op[{gidx, 4'h0} +: 16];
  assign drop = gval && (gidx != 2'd0) &&
                (op_w[11:8] == 4'hF);
  assign push = gval && !drop;
  assign pop  = !empty &&
                ((state_q == IDLE) || (state_q == GAP));

  assign rr_d = gval ? (gidx + 2'd1) : rr_q;

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (push) begin
      wp_d = (wp_q == AW'(FIFO_DEPTH - 1)) ?
             '0 : wp_q + AW'(1);
    end
    if (pop) begin
      rp_d = (rp_q == AW'(FIFO_DEPTH - 1)) ?
             '0 : rp_q + AW'(1);
    end
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Payload storage needs no reset: pointers and count gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q] <= op_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= 2'd0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= 3'd0;
      illegal_q <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      illegal_q <= drop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hold_q   <= 4'd0;
      idx_q    <= 16'h0000;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      unique case (state_q)
        IDLE, GAP: begin
          if (pop) begin
            idx_q    <= mem_q[rp_q];
            strobe_q <= 1'b1;
            hold_q   <= 4'(HOLD_CYCLES - 1);
            state_q  <= DRIVE;
          end else begin
            idx_q   <= 16'h0000;
            state_q <= IDLE;
          end
        end
        DRIVE: begin
          if (hold_q == 4'd0) begin
            idx_q   <= 16'h0000;
            state_q <= GAP;
          end else begin
            hold_q <= hold_q - 4'd1;
          end
        end
        default: begin
          idx_q   <= 16'h0000;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef DISPATCH_DROP_COUNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= 8'd0;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign bus.idx_op    = idx_q;
  assign bus.op_strobe = strobe_q;
  assign illegal_pulse = illegal_q;
  assign fifo_count    = cnt_q;
  assign busy          = (state_q != IDLE) || !empty;

endmodule
